// File: rtl/pulse_scheduler.sv
// Shared active-low pulse timer: a round-robin arbiter picks one requester,
// latches its width, times the pulse on one counter and returns ack or abort.
module pulse_scheduler #(
   parameter int NUM_REQ          = 4,
   parameter int WEIGHT_BIT_WIDTH = 8,
   parameter int GAP_CYCLES       = 1
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic                                enable,
   input  logic [NUM_REQ-1:0]                  req,
   input  logic [NUM_REQ*WEIGHT_BIT_WIDTH-1:0] req_width,
   output logic [NUM_REQ-1:0]                  pulse_out_n,
   output logic [NUM_REQ-1:0]                  ack,
   output logic                                abort,
   output logic                                busy,
   output logic [$clog2(NUM_REQ)-1:0]          grant_id,
   output logic [WEIGHT_BIT_WIDTH-1:0]         timer_val
);

   localparam int IDW = $clog2(NUM_REQ);
   localparam int W   = WEIGHT_BIT_WIDTH;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] PULSE = 2'd1;
   localparam logic [1:0] GAP   = 2'd2;

   // The gap reuses the pulse counter, cleared on entry, so it ends on GAP_CYCLES-1.
   localparam logic [W-1:0]   GAP_LAST = W'(GAP_CYCLES - 1);
   localparam logic [IDW-1:0] LAST_ID  = IDW'(NUM_REQ - 1);

   logic [1:0]         state_reg, state_next;
   logic [IDW-1:0]     ptr_reg, ptr_next;
   logic [IDW-1:0]     grant_reg, grant_next;
   logic [W-1:0]       width_reg, width_next;
   logic [W-1:0]       timer_reg, timer_next;
   logic [NUM_REQ-1:0] pulse_n_reg, pulse_n_next;
   logic [NUM_REQ-1:0] ack_reg, ack_next;
   logic               abort_reg, abort_next;
   logic               busy_reg, busy_next;

   logic [W-1:0]       width_arr [NUM_REQ];
   logic [IDW-1:0]     winner;
   logic [IDW-1:0]     scan_idx;

   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_width
      assign width_arr[gi] = req_width[gi*W +: W];
   end

   // Scan from the pointer downwards so the candidate closest to the pointer is assigned last.
   always_comb begin
      winner   = '0;
      scan_idx = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         scan_idx = IDW'((int'(ptr_reg) + i) % NUM_REQ);
         if (req[scan_idx]) begin
            winner = scan_idx;
         end
      end
   end

   always_comb begin
      state_next   = state_reg;
      ptr_next     = ptr_reg;
      grant_next   = grant_reg;
      width_next   = width_reg;
      timer_next   = timer_reg;
      pulse_n_next = '1;
      ack_next     = '0;
      abort_next   = 1'b0;

      case (state_reg)
         IDLE: begin
            if (enable && (|req)) begin
               grant_next = winner;
               width_next = width_arr[winner];
               ptr_next   = (winner == LAST_ID) ? '0 : winner + IDW'(1);
               if (width_arr[winner] == '0) begin
                  state_next       = GAP;
                  timer_next       = '0;
                  ack_next[winner] = 1'b1;
               end else begin
                  state_next           = PULSE;
                  timer_next           = W'(1);
                  pulse_n_next[winner] = 1'b0;
               end
            end
         end

         PULSE: begin
            // A dropped request takes priority over reaching the programmed width.
            if (!req[grant_reg]) begin
               state_next = GAP;
               timer_next = '0;
               abort_next = 1'b1;
            end else if (timer_reg == width_reg) begin
               state_next          = GAP;
               timer_next          = '0;
               ack_next[grant_reg] = 1'b1;
            end else begin
               timer_next              = timer_reg + W'(1);
               pulse_n_next[grant_reg] = 1'b0;
            end
         end

         GAP: begin
            if (timer_reg == GAP_LAST) begin
               state_next = IDLE;
               timer_next = '0;
            end else begin
               timer_next = timer_reg + W'(1);
            end
         end

         default: begin
            state_next = IDLE;
            timer_next = '0;
         end
      endcase

      busy_next = (state_next != IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg   <= IDLE;
         ptr_reg     <= '0;
         grant_reg   <= '0;
         width_reg   <= '0;
         timer_reg   <= '0;
         pulse_n_reg <= '1;
         ack_reg     <= '0;
         abort_reg   <= 1'b0;
         busy_reg    <= 1'b0;
      end else begin
         state_reg   <= state_next;
         ptr_reg     <= ptr_next;
         grant_reg   <= grant_next;
         width_reg   <= width_next;
         timer_reg   <= timer_next;
         pulse_n_reg <= pulse_n_next;
         ack_reg     <= ack_next;
         abort_reg   <= abort_next;
         busy_reg    <= busy_next;
      end
   end

   assign pulse_out_n = pulse_n_reg;
   assign ack         = ack_reg;
   assign abort       = abort_reg;
   assign busy        = busy_reg;
   assign grant_id    = grant_reg;
   assign timer_val   = timer_reg;

endmodule

// File: tb/tb_pulse_scheduler.sv
// Directed bench for pulse_scheduler: expected ack/abort events are queued when
// stimulus is driven and matched, including their cycle, when the DUT strobes them.
module tb_pulse_scheduler;

   localparam int N = 4;
   localparam int W = 8;
   localparam int G = 1;

   logic           clk;
   logic           rst_n;
   logic           enable;
   logic [N-1:0]   req;
   logic [N*W-1:0] req_width;
   logic [N-1:0]   pulse_out_n;
   logic [N-1:0]   ack;
   logic           abort;
   logic           busy;
   logic [1:0]     grant_id;
   logic [W-1:0]   timer_val;

   typedef struct packed {
      logic [N-1:0] ack;
      logic         abort;
      logic [31:0]  cyc;
   } ev_t;

   ev_t sb_q[$];
   int  tests;
   int  fails;
   int  cyc;
   int  t0;
   int  order [4] = '{0, 1, 3, 0};
   logic [N-1:0] exp_p;

   pulse_scheduler #(
      .NUM_REQ(N),
      .WEIGHT_BIT_WIDTH(W),
      .GAP_CYCLES(G)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .enable(enable),
      .req(req),
      .req_width(req_width),
      .pulse_out_n(pulse_out_n),
      .ack(ack),
      .abort(abort),
      .busy(busy),
      .grant_id(grant_id),
      .timer_val(timer_val)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push_ev(input logic [N-1:0] a, input logic ab, input int c);
      ev_t e;
      e.ack   = a;
      e.abort = ab;
      e.cyc   = c;
      sb_q.push_back(e);
   endtask

   task automatic set_width(input int ch, input logic [W-1:0] w);
      req_width[ch*W +: W] = w;
   endtask

   // Advance one cycle, sample on the falling edge and reconcile strobes with the scoreboard.
   task automatic adv();
      ev_t got;
      ev_t exp;
      @(posedge clk);
      @(negedge clk);
      cyc++;
      if (rst_n) begin
         tests++;
         assert ($countones(~pulse_out_n) <= 1) else begin
            fails++;
            $error("FAIL onehot: observed pulse_out_n %b expected at most one low", pulse_out_n);
         end
      end
      if (ack != '0 || abort) begin
         got.ack   = ack;
         got.abort = abort;
         got.cyc   = cyc;
         $display("[TB] cycle %0d event ack=%b abort=%b grant_id=%0d", cyc, ack, abort, grant_id);
         tests++;
         if (sb_q.size() == 0) begin
            fails++;
            $error("FAIL sb_unexpected: observed ack=%b abort=%b at %0d expected no event", ack, abort, cyc);
         end else begin
            exp = sb_q.pop_front();
            assert (got === exp) else begin
               fails++;
               $error("FAIL sb_event: observed ack=%b abort=%b cyc=%0d expected ack=%b abort=%b cyc=%0d",
                      got.ack, got.abort, got.cyc, exp.ack, exp.abort, exp.cyc);
            end
         end
      end else if (sb_q.size() > 0 && int'(sb_q[0].cyc) < cyc) begin
         exp = sb_q.pop_front();
         tests++;
         fails++;
         $error("FAIL sb_missed: observed no event by %0d expected ack=%b abort=%b at %0d",
                cyc, exp.ack, exp.abort, exp.cyc);
      end
   endtask

   initial begin
      tests     = 0;
      fails     = 0;
      cyc       = 0;
      rst_n     = 1'b0;
      enable    = 1'b0;
      req       = '0;
      req_width = '0;

      // Reset state
      adv();
      adv();
      chk("rst_pulse", pulse_out_n, 4'hF);
      chk("rst_ack", ack, 0);
      chk("rst_abort", abort, 0);
      chk("rst_busy", busy, 0);
      chk("rst_grant", grant_id, 0);
      chk("rst_timer", timer_val, 0);
      rst_n  = 1'b1;
      enable = 1'b1;
      adv();
      chk("idle_busy", busy, 0);

      // Single request on channel 2, width 5; width changed mid-pulse must be ignored
      set_width(2, 8'd5);
      req = 4'b0100;
      t0  = cyc;
      push_ev(4'b0100, 1'b0, t0 + 6);
      adv();
      chk("single_pulse_c1", pulse_out_n, 4'b1011);
      chk("single_busy_c1", busy, 1);
      chk("single_grant", grant_id, 2);
      chk("single_timer_c1", timer_val, 1);
      adv();
      set_width(2, 8'd1);
      chk("single_timer_c2", timer_val, 2);
      for (int i = 3; i <= 5; i++) begin
         adv();
         chk("single_pulse_low", pulse_out_n, 4'b1011);
      end
      chk("single_timer_c5", timer_val, 5);
      adv();
      chk("single_pulse_c6", pulse_out_n, 4'hF);
      chk("single_busy_c6", busy, 1);
      chk("single_gap_timer", timer_val, 0);
      req = '0;
      adv();
      chk("single_busy_c7", busy, 0);

      // Width 0 on channel 1 (pointer is 3, scan wraps to 1)
      set_width(1, 8'd0);
      req = 4'b0010;
      t0  = cyc;
      push_ev(4'b0010, 1'b0, t0 + 1);
      adv();
      chk("w0_pulse", pulse_out_n, 4'hF);
      chk("w0_busy", busy, 1);
      chk("w0_grant", grant_id, 1);
      req = '0;
      adv();
      chk("w0_idle", busy, 0);

      // Pointer now 2: channel 2 must beat channel 0
      set_width(0, 8'd1);
      set_width(2, 8'd1);
      req = 4'b0101;
      t0  = cyc;
      push_ev(4'b0100, 1'b0, t0 + 2);
      adv();
      chk("ptr_grant", grant_id, 2);
      chk("ptr_pulse", pulse_out_n, 4'b1011);
      adv();
      req = '0;
      adv();
      chk("ptr_idle", busy, 0);

      // Abort: width 10 on channel 0, request dropped at cycle 4
      set_width(0, 8'd10);
      req = 4'b0001;
      t0  = cyc;
      push_ev(4'b0000, 1'b1, t0 + 5);
      for (int i = 1; i <= 4; i++) begin
         adv();
         chk("abort_pulse_low", pulse_out_n, 4'b1110);
         chk("abort_timer", timer_val, i);
      end
      req = '0;
      adv();
      chk("abort_pulse_high", pulse_out_n, 4'hF);
      chk("abort_busy", busy, 1);
      adv();
      chk("abort_idle", busy, 0);

      // Drop coincides with width reached: abort wins, no ack
      set_width(1, 8'd3);
      req = 4'b0010;
      t0  = cyc;
      push_ev(4'b0000, 1'b1, t0 + 4);
      repeat (3) adv();
      chk("tie_timer", timer_val, 3);
      req = '0;
      adv();
      chk("tie_pulse_high", pulse_out_n, 4'hF);
      adv();
      chk("tie_idle", busy, 0);

      // Enable low holds off the grant; dropping it mid-pulse does not stop the pulse
      enable = 1'b0;
      set_width(0, 8'd2);
      req = 4'b0001;
      t0  = cyc;
      for (int i = 1; i <= 20; i++) begin
         adv();
         chk("en_busy", busy, 0);
         chk("en_pulse", pulse_out_n, 4'hF);
      end
      enable = 1'b1;
      push_ev(4'b0001, 1'b0, t0 + 23);
      adv();
      chk("en_pulse_c21", pulse_out_n, 4'b1110);
      enable = 1'b0;
      adv();
      chk("en_pulse_c22", pulse_out_n, 4'b1110);
      adv();
      chk("en_pulse_c23", pulse_out_n, 4'hF);
      req = '0;
      adv();
      chk("en_idle", busy, 0);
      enable = 1'b1;

      // Asynchronous reset in cycle 3 of a width-8 pulse on channel 2
      set_width(2, 8'd8);
      req = 4'b0100;
      repeat (3) adv();
      chk("mid_pulse_low", pulse_out_n, 4'b1011);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_pulse", pulse_out_n, 4'hF);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_timer", timer_val, 0);
      chk("mid_rst_grant", grant_id, 0);
      req = '0;
      adv();
      adv();
      rst_n = 1'b1;
      adv();

      // Round robin over 4'b1011 from a reset pointer: 0, 1, 3, 0
      set_width(0, 8'd3);
      set_width(1, 8'd3);
      set_width(3, 8'd3);
      req = 4'b1011;
      t0  = cyc;
      push_ev(4'b0001, 1'b0, t0 + 4);
      push_ev(4'b0010, 1'b0, t0 + 9);
      push_ev(4'b1000, 1'b0, t0 + 14);
      push_ev(4'b0001, 1'b0, t0 + 19);
      for (int k = 1; k <= 19; k++) begin
         adv();
         if (k % 5 == 1) begin
            exp_p = '1;
            exp_p[order[k/5]] = 1'b0;
            chk("rr_grant", grant_id, order[k/5]);
            chk("rr_pulse", pulse_out_n, exp_p);
         end
         if (k == 19) begin
            req = '0;
         end else if (k % 5 == 4) begin
            req[order[k/5]] = 1'b0;
         end else if (k % 5 == 0) begin
            req[order[k/5 - 1]] = 1'b1;
         end
      end
      adv();
      adv();
      chk("rr_idle", busy, 0);
      chk("sb_drain", sb_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/pulse_scheduler.md
# pulse_scheduler

Shares a single programmable pulse timer between `NUM_REQ` requesters, each asking for an active-low output pulse of its own width. A round-robin arbiter grants one requester at a time. The block latches that requester's width, times the pulse on one shared counter, and returns a completion or abort handshake. It sits between the channel control logic and the per-channel active-low delay outputs of the timer subsystem.

## Interface
- `NUM_REQ`, default 4: number of requesters; legal range 2..16.
- `WEIGHT_BIT_WIDTH`, default 8: width of each pulse-width field and of the timer.
- `GAP_CYCLES`, default 1: idle cycles inserted after each pulse; legal range 1..15.

Ports (clock and reset first):
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `enable`  in  1  allows new grants; does not affect a pulse already running.
- `req`  in  NUM_REQ  level request per channel; held high until `ack` or abort.
- `req_width`  in  NUM_REQ*WEIGHT_BIT_WIDTH  pulse width of channel k at bits [k*W +: W]; unit is clk cycles.
- `pulse_out_n`  out  NUM_REQ  active-low pulse per channel; at most one bit low at any time.
- `ack`  out  NUM_REQ  one-cycle completion strobe for the served channel.
- `abort`  out  1  one-cycle strobe when a running pulse is cut short.
- `busy`  out  1  high in every state except IDLE.
- `grant_id`  out  $clog2(NUM_REQ)  channel currently or most recently granted.
- `timer_val`  out  WEIGHT_BIT_WIDTH  current count of the shared timer.

## Operation
- **States:** IDLE, PULSE, GAP. All outputs are registered.
- **Reset values:** state = IDLE; `pulse_out_n` all 1; `ack` = 0; `abort` = 0; `busy` = 0; `grant_id` = 0; `timer_val` = 0; round-robin pointer = 0.
- **IDLE:** if `enable` and `|req`, pick the winner.
  - Scan starts at the pointer and wraps modulo NUM_REQ; the first set bit wins.
  - Latch `grant_id` and the winner's width into an internal register. Later changes to `req_width` are ignored for this pulse.
  - Set the pointer to winner + 1, wrapping to 0 after NUM_REQ-1.
- **Width 0:** no pulse is produced. `ack[winner]` is asserted on the next cycle and the FSM goes directly to GAP.
- **Width W > 0:** enter PULSE with `timer_val` = 1 and `pulse_out_n[winner]` = 0.
- **PULSE, width reached:** when `timer_val` == latched width, go to GAP. On the next cycle `pulse_out_n` returns to 1 and `ack[grant_id]` = 1.
- **PULSE, request dropped:** if `req[grant_id]` is sampled low, go to GAP. On the next cycle `pulse_out_n` returns to 1 and `abort` = 1; `ack` is not asserted.
- **PULSE, both conditions in the same cycle:** the abort wins; `ack` is not asserted.
- **Otherwise in PULSE:** `timer_val` increments by 1. Wrap is impossible because the count never exceeds the latched width.
- **GAP:** lasts exactly GAP_CYCLES cycles, counted on the same counter, which is cleared on entry. Then return to IDLE. All `req` inputs are ignored during GAP.
- **Requester obligation:** a requester deasserts `req` in the cycle after `ack`. A request still high when IDLE is re-entered is treated as a new request.
- **`enable` low:** in IDLE, no grant occurs. Mid-PULSE it has no effect; the pulse finishes and `ack` is still issued.
- **Reset mid-operation:** all outputs go asynchronously to their reset values. No `ack` or `abort` is issued for the interrupted pulse.

## Timing
- **Grant latency:** a request sampled in IDLE at cycle 0 gives `pulse_out_n` low and `busy` high from cycle 1.
- **Pulse length:** `pulse_out_n` is low for exactly W cycles (cycles 1..W). `ack` is high in cycle W+1.
- **GAP span:** cycles W+1..W+GAP_CYCLES.
- **Next grant:** IDLE in cycle W+GAP_CYCLES+1. The next pulse can start at cycle W+GAP_CYCLES+2.
- **Width 0 request at cycle 0:** `ack` in cycle 1, GAP in cycles 1..GAP_CYCLES, IDLE in cycle GAP_CYCLES+1.
- **Abort latency:** `req` sampled low at cycle t gives `pulse_out_n` high and `abort` high at cycle t+1.
- **Back-to-back throughput:** one pulse per W+GAP_CYCLES+1 cycles.

## Test plan
- **Single request:** `req[2]`=1, width=5, GAP_CYCLES=1 → `pulse_out_n[2]` low cycles 1–5; `ack[2]` in cycle 6; `busy` falls in cycle 7.
- **Simultaneous requests:** `req`=4'b1011 held, widths 3, pointer 0 → grants in order 0, 1, 3, 0.
  - Each `ack` is followed by that requester dropping `req` for one cycle, then re-raising it.
- **Width 0:** `req[1]`=1, width=0 → `pulse_out_n` never low; `ack[1]` in cycle 1; pointer moves to 2.
- **Abort:** width=10, `req[0]` dropped at cycle 4 → `pulse_out_n[0]` high at cycle 5; `abort` high at cycle 5; no `ack[0]` at any cycle.
- **Enable:** `enable`=0 with `req`=4'b0001 for 20 cycles → no grant, `busy`=0.
  - Raise `enable` at cycle 20 → `pulse_out_n[0]` low at cycle 21.
- **Reset mid-pulse:** assert `rst_n`=0 at cycle 3 of a width=8 pulse → `pulse_out_n` all 1 and `busy`=0 immediately.
  - After release, the first grant goes to channel 0, since the pointer is reset.
